// File: rtl/div_unit_pkg.sv
// div_unit_pkg: widths, iteration bound and small arithmetic helpers for div_unit.
package div_unit_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   // Index of the final restoring step; CALC runs steps 0..LAST_STEP.
   localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;

   // Two's-complement negation.
   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
      return ~v + 32'd1;
   endfunction

   // Magnitude of v when treated as signed, v itself otherwise.
   function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v, input logic is_signed);
      logic [XLEN-1:0] m;
      if (is_signed && v[XLEN-1]) begin
         m = neg32(v);
      end else begin
         m = v;
      end
      return m;
   endfunction

   // RISC-V M results for divide-by-zero and signed overflow.
   function automatic logic [XLEN-1:0] special_result(input logic is_rem,
                                                      input logic div_zero,
                                                      input logic [XLEN-1:0] dividend);
      logic [XLEN-1:0] r;
      if (div_zero) begin
         r = is_rem ? dividend : ALL_ONES;
      end else begin
         r = is_rem ? 32'd0 : INT_MIN;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring-division step. Takes the already-shifted 33-bit
// partial remainder, trial-subtracts the divisor and returns the next
// remainder and the quotient bit.
module div_step
   import div_unit_pkg::*;
(
   input  logic [XLEN:0]   rem_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN-1:0] diff_s;

   // Trial subtract; keep the difference only when it does not go negative.
   // When it succeeds the true difference is below the divisor, so the low
   // 32 bits of the subtraction are exact.
   always_comb begin
      q_bit  = (rem_in >= {1'b0, divisor});
      diff_s = rem_in[XLEN-1:0] - divisor;
      if (q_bit) begin
         rem_out = diff_s;
      end else begin
         rem_out = rem_in[XLEN-1:0];
      end
   end

endmodule

// File: rtl/mydefine.sv
// Shared defines: funct3 encodings of the RISC-V M-extension divide/remainder ops.
`ifndef MYDEFINE_SV
`define MYDEFINE_SV

`define F_DIV  3'b100
`define F_DIVU 3'b101
`define F_REM  3'b110
`define F_REMU 3'b111

`endif

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit DIV/DIVU/REM/REMU unit (restoring, 1 bit/cycle).
// Fixed latency: start_ sampled in cycle 0, done_ pulses in cycle 34.
// Optional macro DIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed overflow
// skip CALC/FIX and finish in cycle 1 without raising busy_.
`include "mydefine.sv"

module div_unit
   import div_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_,
   input  logic [2:0]      funct3_,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   output logic            busy_,
   output logic            done_,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [2:0]      funct3_r;
   logic [XLEN-1:0] dividend_r;   // original dividend, needed for x/0 remainder
   logic [XLEN-1:0] divisor_r;    // divisor magnitude
   logic [XLEN-1:0] quo_r;        // dividend magnitude shifting out, quotient shifting in
   logic [XLEN-1:0] rem_r;        // partial remainder
   logic [CNT_W-1:0] cnt_r;
   logic            q_neg_r, r_neg_r, div_zero_r, ovf_r;
   logic            busy_r, done_r;
   logic [XLEN-1:0] result_r;

   logic            signed_in_s, zero_in_s, ovf_in_s, is_rem_op_s;
   logic            busy_s, done_s, step_q_s;
   logic [XLEN-1:0] step_rem_s, fix_q_s, fix_r_s, final_s;

`ifdef DIV_SPECIAL_FASTPATH_EN
   logic            special_s, is_rem_in_s;
   logic [XLEN-1:0] spec_res_s;
`endif

   assign busy_  = busy_r;
   assign done_  = done_r;
   assign result = result_r;

   div_step u_step (
      .rem_in  ({rem_r, quo_r[XLEN-1]}),
      .divisor (divisor_r),
      .rem_out (step_rem_s),
      .q_bit   (step_q_s)
   );

   // Decode the incoming request: signedness and the two special cases.
   always_comb begin
      signed_in_s = (funct3_ == `F_DIV) || (funct3_ == `F_REM);
      zero_in_s   = (rs2_value == 32'd0);
      ovf_in_s    = signed_in_s && (rs1_value == INT_MIN) && (rs2_value == ALL_ONES);
`ifdef DIV_SPECIAL_FASTPATH_EN
      special_s   = zero_in_s || ovf_in_s;
      is_rem_in_s = (funct3_ == `F_REM) || (funct3_ == `F_REMU);
      spec_res_s  = special_result(is_rem_in_s, zero_in_s, rs1_value);
`endif
   end

   // Sign correction and result selection used in FIX.
   always_comb begin
      is_rem_op_s = (funct3_r == `F_REM) || (funct3_r == `F_REMU);
      if (q_neg_r) begin
         fix_q_s = neg32(quo_r);
      end else begin
         fix_q_s = quo_r;
      end
      if (r_neg_r) begin
         fix_r_s = neg32(rem_r);
      end else begin
         fix_r_s = rem_r;
      end
      if (div_zero_r || ovf_r) begin
         final_s = special_result(is_rem_op_s, div_zero_r, dividend_r);
      end else begin
         final_s = is_rem_op_s ? fix_r_s : fix_q_s;
      end
   end

   // Next-state logic plus next values of the registered handshake outputs.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_) begin
`ifdef DIV_SPECIAL_FASTPATH_EN
               state_s = special_s ? DONE : CALC;
`else
               state_s = CALC;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == LAST_STEP) begin
               state_s = FIX;
            end else begin
               state_s = CALC;
            end
         end
         FIX:     state_s = DONE;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
      busy_s = (state_s == CALC) || (state_s == FIX);
      done_s = (state_s == DONE);
   end

   // State and handshake output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   // Datapath: operand capture, one restoring step per CALC cycle, result in FIX.
   always_ff @(posedge clk) begin
      if (rst) begin
         funct3_r   <= 3'd0;
         dividend_r <= 32'd0;
         divisor_r  <= 32'd0;
         quo_r      <= 32'd0;
         rem_r      <= 32'd0;
         cnt_r      <= 6'd0;
         q_neg_r    <= 1'b0;
         r_neg_r    <= 1'b0;
         div_zero_r <= 1'b0;
         ovf_r      <= 1'b0;
         result_r   <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_) begin
                  funct3_r   <= funct3_;
                  dividend_r <= rs1_value;
                  divisor_r  <= mag32(rs2_value, signed_in_s);
                  quo_r      <= mag32(rs1_value, signed_in_s);
                  rem_r      <= 32'd0;
                  cnt_r      <= 6'd0;
                  q_neg_r    <= signed_in_s && (rs1_value[XLEN-1] ^ rs2_value[XLEN-1]);
                  r_neg_r    <= signed_in_s && rs1_value[XLEN-1];
                  div_zero_r <= zero_in_s;
                  ovf_r      <= ovf_in_s;
`ifdef DIV_SPECIAL_FASTPATH_EN
                  if (special_s) begin
                     result_r <= spec_res_s;
                  end
`endif
               end
            end
            CALC: begin
               rem_r <= step_rem_s;
               quo_r <= {quo_r[XLEN-2:0], step_q_s};
               cnt_r <= cnt_r + 6'd1;
            end
            FIX: begin
               result_r <= final_s;
            end
            DONE: begin
               cnt_r <= 6'd0;
            end
            default: begin
               cnt_r <= 6'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

`ifdef DIV_SPECIAL_FASTPATH_EN
   localparam int SPEC_LAT  = 1;
   localparam int SPEC_BUSY = 0;
`else
   localparam int SPEC_LAT  = 34;
   localparam int SPEC_BUSY = 33;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_ = 1'b0;
   logic [2:0]  funct3_ = 3'b000;
   logic [31:0] rs1_value = 32'd0;
   logic [31:0] rs2_value = 32'd0;
   logic        busy_;
   logic        done_;
   logic [31:0] result;

   int tests_run = 0;
   int tests_failed = 0;

   div_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start_    (start_),
      .funct3_   (funct3_),
      .rs1_value (rs1_value),
      .rs2_value (rs2_value),
      .busy_     (busy_),
      .done_     (done_),
      .result    (result)
   );

   always #5 clk = ~clk;

   // Issue one op; returns done_ cycle (-1 on timeout), result at done_, busy cycles seen.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output int busy_cnt);
      @(negedge clk);
      start_ = 1'b1; funct3_ = f; rs1_value = a; rs2_value = b;
      @(negedge clk);
      start_ = 1'b0;
      lat = -1; res = 32'hxxxx_xxxx; busy_cnt = 0;
      for (int k = 1; k <= 60; k++) begin
         if (busy_) busy_cnt++;
         if (done_) begin
            lat = k; res = result;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests_run++; if (busy_ !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_); end
      tests_run++; if (done_ !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_); end
      tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", result); end
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int lat, bc; logic [31:0] res;
      do_op(OP_DIVU, 32'd100, 32'd7, lat, res, bc);
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL divu_latency: got %0d want 34", lat); end
      tests_run++; if (res !== 32'd14) begin tests_failed++; $display("FAIL divu_100_7: got %h want 0000000e", res); end
      tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL divu_busy_cycles: got %0d want 33", bc); end
      @(negedge clk);
      tests_run++; if (done_ !== 1'b0) begin tests_failed++; $display("FAIL done_single_pulse: got %b want 0", done_); end
      do_op(OP_REMU, 32'd100, 32'd7, lat, res, bc);
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL remu_latency: got %0d want 34", lat); end
      tests_run++; if (res !== 32'd2) begin tests_failed++; $display("FAIL remu_100_7: got %h want 00000002", res); end
      repeat (4) @(negedge clk);
      tests_run++; if (result !== 32'd2) begin tests_failed++; $display("FAIL result_hold: got %h want 00000002", result); end
      do_op(OP_DIVU, 32'hDEAD_BEEF, 32'h10, lat, res, bc);
      tests_run++; if (res !== 32'h0DEA_DBEE) begin tests_failed++; $display("FAIL divu_deadbeef_16: got %h want 0deadbee", res); end
      do_op(OP_REMU, 32'hDEAD_BEEF, 32'h10, lat, res, bc);
      tests_run++; if (res !== 32'h0000_000F) begin tests_failed++; $display("FAIL remu_deadbeef_16: got %h want 0000000f", res); end
      do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu_max_1: got %h want ffffffff", res); end
   endtask

   task automatic test_signed();
      int lat, bc; logic [31:0] res;
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL div_latency: got %0d want 34", lat); end
      do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_7_m2: got %h want fffffffd", res); end
      do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res, bc);
      tests_run++; if (res !== 32'd1) begin tests_failed++; $display("FAIL rem_7_m2: got %h want 00000001", res); end
   endtask

   task automatic test_div_zero();
      int lat, bc; logic [31:0] res;
      do_op(OP_DIV, 32'd5, 32'd0, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_5_0: got %h want ffffffff", res); end
      tests_run++; if (lat !== SPEC_LAT) begin tests_failed++; $display("FAIL div0_latency: got %0d want %0d", lat, SPEC_LAT); end
      tests_run++; if (bc !== SPEC_BUSY) begin tests_failed++; $display("FAIL div0_busy_cycles: got %0d want %0d", bc, SPEC_BUSY); end
      do_op(OP_REM, 32'd5, 32'd0, lat, res, bc);
      tests_run++; if (res !== 32'd5) begin tests_failed++; $display("FAIL rem_5_0: got %h want 00000005", res); end
      do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_m5_0: got %h want ffffffff", res); end
      do_op(OP_REMU, 32'hFFFF_FFF9, 32'd0, lat, res, bc);
      tests_run++; if (res !== 32'hFFFF_FFF9) begin tests_failed++; $display("FAIL remu_x_0: got %h want fffffff9", res); end
   endtask

   task automatic test_overflow();
      int lat, bc; logic [31:0] res;
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc);
      tests_run++; if (res !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_overflow: got %h want 80000000", res); end
      tests_run++; if (lat !== SPEC_LAT) begin tests_failed++; $display("FAIL ovf_latency: got %0d want %0d", lat, SPEC_LAT); end
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc);
      tests_run++; if (res !== 32'd0) begin tests_failed++; $display("FAIL rem_overflow: got %h want 00000000", res); end
      do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc);
      tests_run++; if (res !== 32'd0) begin tests_failed++; $display("FAIL divu_not_ovf: got %h want 00000000", res); end
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL divu_not_ovf_latency: got %0d want 34", lat); end
      do_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc);
      tests_run++; if (res !== 32'h8000_0000) begin tests_failed++; $display("FAIL remu_not_ovf: got %h want 80000000", res); end
   endtask

   task automatic test_reset_mid_op();
      int seen_done, seen_busy, lat, bc; logic [31:0] res;
      @(negedge clk);
      start_ = 1'b1; funct3_ = OP_DIVU; rs1_value = 32'd100; rs2_value = 32'd7;
      @(negedge clk);
      start_ = 1'b0;
      repeat (9) @(negedge clk);
      tests_run++; if (busy_ !== 1'b1) begin tests_failed++; $display("FAIL busy_mid_op: got %b want 1", busy_); end
      rst = 1'b1; start_ = 1'b1; funct3_ = OP_REMU; rs1_value = 32'd50; rs2_value = 32'd3;
      @(negedge clk);
      tests_run++; if (busy_ !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy_); end
      tests_run++; if (done_ !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", done_); end
      tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL rst_result: got %h want 0", result); end
      rst = 1'b0; start_ = 1'b0;
      seen_done = 0; seen_busy = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done_) seen_done++;
         if (busy_) seen_busy++;
      end
      tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL no_done_after_rst: got %0d pulses want 0", seen_done); end
      tests_run++; if (seen_busy !== 0) begin tests_failed++; $display("FAIL start_in_rst_ignored: got %0d busy cycles want 0", seen_busy); end
      do_op(OP_REMU, 32'd50, 32'd3, lat, res, bc);
      tests_run++; if (res !== 32'd2) begin tests_failed++; $display("FAIL recover_remu_50_3: got %h want 00000002", res); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] res;
      @(negedge clk);
      start_ = 1'b1; funct3_ = OP_DIVU; rs1_value = 32'd100; rs2_value = 32'd7;
      @(negedge clk);
      lat = -1; res = 32'd0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 5) begin
            funct3_ = OP_REMU; rs1_value = 32'd1000; rs2_value = 32'd7;
         end
         if (done_) begin
            lat = k; res = result;
            break;
         end
         @(negedge clk);
      end
      tests_run++; if (res !== 32'd14) begin tests_failed++; $display("FAIL start_ignored_result: got %h want 0000000e", res); end
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL start_ignored_latency: got %0d want 34", lat); end
      // start_ still high: the IDLE cycle after DONE accepts the new operands
      @(negedge clk);
      @(negedge clk);
      start_ = 1'b0;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         if (done_) begin
            lat = k; res = result;
            break;
         end
         @(negedge clk);
      end
      tests_run++; if (res !== 32'd6) begin tests_failed++; $display("FAIL back_to_back_result: got %h want 00000006", res); end
      tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL back_to_back_latency: got %0d want 34", lat); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_reset_mid_op();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
